// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Brief    : Main sequencer for a multicycle datapath. Steps each instruction
//             through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives datapath
//             write enables, mux selects and memory strobes, and stalls on a
//             memory ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ABWrite,
  output logic       OutWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  state_t r_state;

  // Opcode decode used by DECODE for both next-state and the Illegal pulse.
  logic w_op_mem;
  logic w_op_known;

  assign w_op_mem   = (Opcode == OP_LW) || (Opcode == OP_SW);
  assign w_op_known = w_op_mem || (Opcode == OP_RTYPE) ||
                      (Opcode == OP_BEQ) || (Opcode == OP_J);

  assign State = r_state;

  // State register: sequences instructions and holds on memory stalls.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= MemReady ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (w_op_mem)                r_state <= S_MEMADR;
          else if (Opcode == OP_RTYPE) r_state <= S_EXEC;
          else if (Opcode == OP_BEQ)   r_state <= S_BRANCH;
          else if (Opcode == OP_J)     r_state <= S_JUMP;
          else                         r_state <= S_FETCH;
        end
        S_MEMADR: r_state <= (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  r_state <= MemReady ? S_MEMWB : S_MEMRD;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  r_state <= MemReady ? S_FETCH : S_MEMWR;
        S_EXEC:   r_state <= S_RWB;
        S_RWB:    r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode from the current state; MemReady/Zero qualify enables
  // directly, and Reset forces every enable and strobe low so an aborted
  // access never commits.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MDRWrite = 1'b0;
    ABWrite  = 1'b0;
    OutWrite = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    ALUOp    = 2'd0;
    PCSource = 2'd0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    Illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ABWrite  = 1'b1;
        OutWrite = 1'b1;
        ALUSrcB  = 2'd3;
        Illegal  = ~w_op_known;
      end
      S_MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'd2;
        OutWrite = 1'b1;
      end
      S_MEMRD: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        MDRWrite = MemReady;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'd2;
        OutWrite = 1'b1;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'd1;
        PCSource = 2'd1;
        PCWrite  = Zero;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
    if (Reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MDRWrite = 1'b0;
      ABWrite  = 1'b0;
      OutWrite = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Brief    : Directed self-checking bench for multicycle_ctrl_fsm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IRWrite, MDRWrite, ABWrite, OutWrite, RegWrite;
  logic       MemRead, MemWrite, IorD, ALUSrcA, RegDst, MemtoReg, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl_fsm dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MDRWrite(MDRWrite), .ABWrite(ABWrite),
    .OutWrite(OutWrite), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg), .Illegal(Illegal),
    .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle at the following negedge; inputs for the
  // new cycle are driven by the caller afterwards, then outputs settle #1.
  task automatic next_cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  function automatic logic [7:0] all_en();
    return {PCWrite, IRWrite, MDRWrite, ABWrite, OutWrite, RegWrite, MemRead, MemWrite};
  endfunction

  initial begin
    Reset = 1'b1; Opcode = 6'h00; Zero = 1'b0; MemReady = 1'b1;

    // Reset held two cycles: everything quiet, State forced to FETCH.
    @(negedge Clk); #1;
    chk("rst_en0", all_en(), 8'h00);
    chk("rst_ill0", {7'd0, Illegal}, 8'h00);
    next_cycle(); #1;
    chk("rst_state", {4'd0, State}, 8'd0);
    chk("rst_en1", all_en(), 8'h00);

    // Release: first FETCH with MemReady=1 fires IR/PC writes.
    Reset = 1'b0; #1;
    chk("fetch_state", {4'd0, State}, 8'd0);
    chk("fetch_en", all_en(), 8'b1100_0010);
    chk("fetch_srcb", {6'd0, ALUSrcB}, 8'd1);

    // R-type: 0,1,6,7,0. Opcode change in EXEC must not matter.
    next_cycle(); #1;
    chk("r_dec_state", {4'd0, State}, 8'd1);
    chk("r_dec_en", all_en(), 8'b0001_1000);
    chk("r_dec_srcb", {6'd0, ALUSrcB}, 8'd3);
    next_cycle(); Opcode = 6'h2B; #1;
    chk("r_exec_state", {4'd0, State}, 8'd6);
    chk("r_exec_sel", {ALUSrcA, OutWrite, ALUOp, ALUSrcB, 2'b00}, 8'b1110_0000);
    next_cycle(); #1;
    chk("r_rwb_state", {4'd0, State}, 8'd7);
    chk("r_rwb_sig", {RegWrite, RegDst, MemtoReg, PCWrite, 4'd0}, 8'b1100_0000);
    next_cycle(); #1;
    chk("r_back_fetch", {4'd0, State}, 8'd0);

    // LW with 3 stall cycles in MEMRD.
    Opcode = 6'h23;
    next_cycle(); #1;
    chk("lw_dec", {4'd0, State}, 8'd1);
    next_cycle(); #1;
    chk("lw_memadr", {4'd0, State}, 8'd2);
    chk("lw_memadr_sel", {ALUSrcA, OutWrite, ALUSrcB, 4'd0}, 8'b1110_0000);
    next_cycle(); MemReady = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_stall_state", {4'd0, State}, 8'd3);
      chk("lw_stall_en", all_en(), 8'b0000_0010);
      next_cycle(); #1;
    end
    MemReady = 1'b1; #1;
    chk("lw_rd_state", {4'd0, State}, 8'd3);
    chk("lw_rd_en", all_en(), 8'b0010_0010);
    chk("lw_rd_iord", {7'd0, IorD}, 8'd1);
    next_cycle(); #1;
    chk("lw_wb_state", {4'd0, State}, 8'd4);
    chk("lw_wb_sig", {RegWrite, RegDst, MemtoReg, 5'd0}, 8'b1010_0000);
    next_cycle(); #1;
    chk("lw_back_fetch", {4'd0, State}, 8'd0);

    // BEQ not taken then taken.
    Opcode = 6'h04; Zero = 1'b0;
    next_cycle(); next_cycle(); #1;
    chk("beq0_state", {4'd0, State}, 8'd8);
    chk("beq0_sig", {PCWrite, ALUSrcA, ALUOp, PCSource, 2'd0}, 8'b0101_0100);
    next_cycle(); #1;
    chk("beq0_fetch", {4'd0, State}, 8'd0);
    next_cycle(); next_cycle(); Zero = 1'b1; #1;
    chk("beq1_state", {4'd0, State}, 8'd8);
    chk("beq1_sig", {PCWrite, ALUSrcA, ALUOp, PCSource, 2'd0}, 8'b1101_0100);
    next_cycle(); Zero = 1'b0; #1;

    // Illegal opcode in DECODE.
    Opcode = 6'h3F;
    next_cycle(); #1;
    chk("ill_dec_state", {4'd0, State}, 8'd1);
    chk("ill_pulse", {Illegal, RegWrite, MemWrite, 5'd0}, 8'b1000_0000);
    next_cycle(); #1;
    chk("ill_fetch", {4'd0, State}, 8'd0);
    chk("ill_gone", {Illegal, RegWrite, MemWrite, 5'd0}, 8'h00);

    // Jump.
    Opcode = 6'h02;
    next_cycle(); next_cycle(); #1;
    chk("j_state", {4'd0, State}, 8'd9);
    chk("j_sig", {PCWrite, RegWrite, PCSource, 4'd0}, 8'b1010_0000);
    next_cycle(); #1;
    chk("j_fetch", {4'd0, State}, 8'd0);

    // SW, reset on second MEMWR stall cycle aborts the write.
    Opcode = 6'h2B;
    next_cycle(); next_cycle(); #1;
    chk("sw_memadr", {4'd0, State}, 8'd2);
    next_cycle(); MemReady = 1'b0; #1;
    chk("sw_wr1_state", {4'd0, State}, 8'd5);
    chk("sw_wr1_en", all_en(), 8'b0000_0001);
    next_cycle(); Reset = 1'b1; #1;
    chk("sw_wr2_state", {4'd0, State}, 8'd5);
    chk("sw_wr2_abort", all_en(), 8'h00);
    next_cycle(); Reset = 1'b0; MemReady = 1'b1; #1;
    chk("sw_rst_fetch", {4'd0, State}, 8'd0);

    // Random-opcode run checking invariants every cycle.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: Opcode = 6'h00;
        1: Opcode = 6'h23;
        2: Opcode = 6'h2B;
        3: Opcode = 6'h04;
        4: Opcode = 6'h02;
        default: Opcode = 6'($urandom_range(0, 63));
      endcase
      MemReady = ($urandom_range(0, 3) != 0);
      Zero     = $urandom_range(0, 1) == 1;
      #1;
      chk("inv_mem", {7'd0, MemRead & MemWrite}, 8'd0);
      chk("inv_regpc", {7'd0, RegWrite & PCWrite}, 8'd0);
      chk("inv_range", {7'd0, State > 4'd9}, 8'd0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
